// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (FETCH / FULL / BUBBLE)
//   fetch_entry_t : one buffered instruction word plus its address
//   FETCH_DEPTH   : number of entries in the skid buffer
//   NOP_INST      : word the firmware returns for the bubble address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int          FETCH_DEPTH = 2;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// Two-entry in-order buffer of {inst, pc}. Entry 0 is always the head, so
// the decode-side outputs come straight from a register and stay stable
// while the head is not popped.
// Ports:
//   clk, reset     clock, synchronous active-high reset (clears entries)
//   push/push_data write one entry at the tail
//   pop            remove the head (ignored when empty)
//   flush          drop all entries (wins over push/pop)
//   head           current head entry
//   occupancy      number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   occupancy
);

    fetch_entry_t entry [FETCH_DEPTH];
    logic [1:0]   count;
    logic         pop_ok;
    logic         push_ok;
    logic         wr_idx;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    // Tail slot after the pop has shifted the buffer: slot 1 only when one
    // entry remains in front of the new word.
    assign wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop_ok) begin
                entry[0] <= entry[1];
            end
            // Placed after the shift so a push into slot 0 overrides it.
            if (push_ok) begin
                entry[wr_idx] <= push_data;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head      = entry[0];
    assign occupancy = count;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Owns the PC, presents it to the memory controller, buffers returned
// instructions for decode and handles redirects from execute.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | waiting for the controller pulse for inst_mem_addr
// FULL   | buffer full, address already served, waiting for a pop
// BUBBLE | driving BUBBLE_ADDR for one cycle so the controller re-fetches
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   inst_mem_addr     fetch address to the memory controller
//   mem_stall         low for one cycle when mem_inst is valid
//   mem_inst          instruction word from the controller
//   redirect_valid/pc branch/jump redirect from execute
//   dec_valid/inst/pc instruction and address offered to decode
//   dec_ready         decode accepts this cycle
//   perf_fetched      (FETCH_PERF_CNT_EN only) accepted pulses
//   perf_stall_cycles (FETCH_PERF_CNT_EN only) FETCH cycles with mem_stall
//
// Optional feature: define FETCH_PERF_CNT_EN to add the two counters.
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_ADDR = 32'hFFFF_FFFC,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_mem_addr,
    input  logic        mem_stall,
    input  logic [31:0] mem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  addr;
    logic [31:0]  addr_next;
    logic [31:0]  target;
    logic [31:0]  target_next;
    logic         push;
    logic         pop;
    logic         flush;
    logic [1:0]   occupancy;
    logic [1:0]   occ_after;
    fetch_entry_t head;
    fetch_entry_t push_data;

    assign pop       = dec_valid && dec_ready;
    assign push_data = '{inst: mem_inst, pc: addr};

    fetch_skid_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .occupancy (occupancy)
    );

    assign dec_valid     = (occupancy != 2'd0);
    assign dec_inst      = head.inst;
    assign dec_pc        = head.pc;
    assign inst_mem_addr = addr;

    // Occupancy after this cycle's push and pop, assuming a push happens.
    assign occ_after = occupancy + 2'd1 - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            addr   <= RESET_PC;
            target <= RESET_PC;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            target <= target_next;
        end
    end

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        target_next = target;
        push        = 1'b0;
        flush       = 1'b0;

        if (redirect_valid) begin
            flush = 1'b1;
            if (redirect_pc != addr) begin
                addr_next  = redirect_pc;
                state_next = FETCH;
            end else if (state == FULL) begin
                // The controller already served this address; force it to
                // see an address change so it fetches the target again.
                addr_next   = BUBBLE_ADDR;
                target_next = redirect_pc;
                state_next  = BUBBLE;
            end else if (state == BUBBLE) begin
                // Only reachable with a target equal to BUBBLE_ADDR.
                target_next = redirect_pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_stall) begin
                        push = 1'b1;
                        if (occ_after < 2'(FETCH_DEPTH)) begin
                            addr_next = addr + PC_STEP;
                        end else begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        addr_next  = addr + PC_STEP;
                        state_next = FETCH;
                    end
                end
                BUBBLE: begin
                    addr_next  = target;
                    state_next = FETCH;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == FETCH) && mem_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_ADDR = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP     = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_mem_addr;
    logic        mem_stall;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .BUBBLE_ADDR (BUBBLE_ADDR),
        .PC_STEP     (PC_STEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_mem_addr  (inst_mem_addr),
        .mem_stall      (mem_stall),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // Reference model: a queue of instructions owed to decode, the address
    // the unit should be presenting, and what it is waiting for.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef enum {M_FETCHING, M_WAIT_POP, M_BUBBLE} mmode_t;

    exp_t        exp_q[$];
    mmode_t      m_mode;
    logic [31:0] m_addr;
    logic [31:0] m_target;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit just_reset = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle; a transfer removes the head.
    always @(negedge clk) begin
        if (started) begin
            check32("inst_mem_addr", inst_mem_addr, m_addr);
            check32("dec_valid", {31'd0, dec_valid}, {31'd0, exp_q.size() != 0});
            if (just_reset) begin
                check32("reset_dec_inst", dec_inst, 32'd0);
                check32("reset_dec_pc", dec_pc, 32'd0);
            end
            if (exp_q.size() != 0) begin
                check32("dec_pc", dec_pc, exp_q[0].pc);
                check32("dec_inst", dec_inst, exp_q[0].inst);
                if (dec_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs, then advance the model across the edge.
    task automatic step(input bit rst, input bit stall, input logic [31:0] inst,
                        input bit rv, input logic [31:0] rpc, input bit rdy);
        bit popped;
        reset          = rst;
        mem_stall      = stall;
        mem_inst       = inst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        popped = rdy && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        just_reset = 0;
        if (rst) begin
            exp_q.delete();
            m_mode     = M_FETCHING;
            m_addr     = RESET_PC;
            m_target   = RESET_PC;
            just_reset = 1;
            started    = 1;
        end else if (rv) begin
            exp_q.delete();
            if (rpc != m_addr) begin
                m_addr = rpc;
                m_mode = M_FETCHING;
            end else if (m_mode == M_WAIT_POP) begin
                m_target = rpc;
                m_addr   = BUBBLE_ADDR;
                m_mode   = M_BUBBLE;
            end else if (m_mode == M_BUBBLE) begin
                m_target = rpc;
            end
        end else begin
            case (m_mode)
                M_FETCHING: begin
                    if (!stall) begin
                        exp_q.push_back('{inst: inst, pc: m_addr});
                        if (exp_q.size() < 2) m_addr = m_addr + PC_STEP;
                        else                  m_mode = M_WAIT_POP;
                    end
                end
                M_WAIT_POP: begin
                    if (popped) begin
                        m_addr = m_addr + PC_STEP;
                        m_mode = M_FETCHING;
                    end
                end
                default: begin
                    m_addr = m_target;
                    m_mode = M_FETCHING;
                end
            endcase
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 1, 32'd0, 0, 32'd0, rdy);
    endtask

    task automatic pulse(input logic [31:0] inst, input bit rdy);
        step(0, 0, inst, 0, 32'd0, rdy);
    endtask

    initial begin
        reset = 1; mem_stall = 1; mem_inst = 0;
        redirect_valid = 0; redirect_pc = 0; dec_ready = 0;

        // Sequential fetch with decode always ready.
        step(1, 1, 32'd0, 0, 32'd0, 1);
        pulse(32'h00A0_0093, 1);
        pulse(32'h0010_0113, 1);
        idle(1); idle(1);

        // Fill the buffer, then release one entry.
        step(1, 1, 32'd0, 0, 32'd0, 0);
        pulse(32'h1111_0001, 0);
        pulse(32'h2222_0002, 0);
        idle(0); idle(0);
        idle(1);
        idle(0);
        pulse(32'h3333_0003, 1);
        idle(1); idle(1);

        // Redirect colliding with a pulse while one entry is buffered.
        step(1, 1, 32'd0, 0, 32'd0, 0);
        pulse(32'h4444_0004, 0);
        step(0, 0, 32'h5555_0005, 1, 32'h0000_0040, 0);
        pulse(32'h6666_0006, 1);
        idle(1);

        // Redirect to the held address while FULL forces a bubble.
        step(1, 1, 32'd0, 0, 32'd0, 1);
        pulse(32'h7777_0007, 1);
        pulse(32'h8888_0008, 1);
        pulse(32'h9999_0009, 0);
        step(0, 1, 32'd0, 1, 32'h0000_0008, 0);
        step(0, 0, NOP_INST, 0, 32'd0, 1);
        pulse(32'hAAAA_000A, 1);
        idle(1); idle(1);

        // Reset while FULL.
        pulse(32'hBBBB_000B, 0);
        pulse(32'hCCCC_000C, 0);
        step(1, 1, 32'd0, 0, 32'd0, 0);
        idle(1); idle(1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          rst;
            bit          rv;
            bit          stall;
            bit          rdy;
            logic [31:0] rpc;
            logic [31:0] inst;
            rst   = ($urandom_range(0, 299) == 0);
            rv    = ($urandom_range(0, 9) == 0);
            stall = !((m_mode != M_WAIT_POP) && ($urandom_range(0, 2) == 0));
            rdy   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = m_addr;
                1:       rpc = BUBBLE_ADDR;
                2:       rpc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                default: rpc = {$urandom() >> 2, 2'b00};
            endcase
            inst = (m_mode == M_BUBBLE) ? NOP_INST : $urandom();
            step(rst, stall, inst, rv, rpc, rdy);
        end
        idle(1); idle(1); idle(1);

`ifdef FETCH_PERF_CNT_EN
        step(1, 1, 32'd0, 0, 32'd0, 1);
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 5; s++) idle(1);
            pulse(32'hD000_0000 + 32'(p), 1);
        end
        @(negedge clk);
        check32("perf_fetched", perf_fetched, 32'd3);
        check32("perf_stall_cycles", perf_stall_cycles, 32'd15);
`endif

        idle(1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream partner of the memory controller's instruction side.
- Owns the PC and drives `inst_mem_addr` out.
- Consumes the controller's `stall` / `inst_mem_read` pulse and buffers up to 2 fetched instructions in a skid buffer. The buffer feeds decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUBBLE_ADDR, 32'hFFFF_FFFC, dummy address driven for one cycle to force an address-change detect.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_mem_addr  out  32  address presented to the memory controller
- mem_stall  in  1  memory controller stall; 0 for exactly one cycle when `mem_inst` is valid
- mem_inst  in  32  instruction word from the memory controller, valid when `mem_stall` = 0
- redirect_valid  in  1  one-cycle redirect request from execute
- redirect_pc  in  32  redirect target, word aligned
- dec_valid  out  1  instruction available to decode
- dec_inst  out  32  instruction word
- dec_pc  out  32  address of `dec_inst`
- dec_ready  in  1  decode accepts this cycle

Behaviour:
- Reset/clock: already decided — clock `clk`; `reset` is synchronous, active-high.
- Reset values: `inst_mem_addr` = RESET_PC, `dec_valid` = 0, `dec_inst` = 0, `dec_pc` = 0, occupancy = 0, state = FETCH.
- Buffer:
  - 2-entry in-order buffer; head drives the `dec_*` ports.
  - A transfer occurs when `dec_valid & dec_ready`.
  - Occupancy is 0..2; a push and a pop may occur in the same cycle.
- State FETCH (waiting for a pulse at address A = `inst_mem_addr`):
  - On `mem_stall` = 0, push {`mem_inst`, A}.
  - If occupancy after the push and pop < 2: `inst_mem_addr` <= A + PC_STEP (32-bit wrap); stay in FETCH.
  - Otherwise: hold `inst_mem_addr` = A and go to FULL.
- State FULL:
  - The address is held; the controller has already served A.
  - The first cycle with a pop: `inst_mem_addr` <= A + PC_STEP, go to FETCH.
  - `mem_stall` = 0 in FULL is ignored (cannot legally occur).
- Latency: from the `mem_stall` = 0 cycle, `dec_valid` is high next cycle when the buffer was empty.
- Redirect (priority over every other event in the same cycle):
  - Flush both entries; `dec_valid` <= 0 next cycle.
  - Discard any simultaneous pulse.
  - If `redirect_pc` != current `inst_mem_addr`: `inst_mem_addr` <= `redirect_pc`, go to FETCH.
  - If equal and state = FETCH: keep the address; the in-flight fetch is already correct.
  - If equal and state = FULL: go to BUBBLE.
- State BUBBLE (one cycle):
  - Drive `inst_mem_addr` = BUBBLE_ADDR; store the target.
  - Next cycle drive the target and go to FETCH.
  - Any pulse belonging to BUBBLE_ADDR is discarded.
- Redirect during BUBBLE: replace the stored target and remain one more BUBBLE cycle only if the new target equals BUBBLE_ADDR; otherwise go straight to the new target.
- `dec_pc`/`dec_inst` are stable while `dec_valid` & !`dec_ready`.
- Reset mid-operation overrides everything and returns to the reset values.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs `perf_fetched` [31:0] (counts accepted pulses) and `perf_stall_cycles` [31:0] (counts cycles in FETCH with `mem_stall` = 1).
  - Both reset to 0 and wrap at 2^32.
  - Flushed instructions still count as fetched.
- Undefined: the ports and counters are absent, with no other difference.

Decomposition:
- Package `fetch_pkg`:
  - State encoding: FETCH = 2'd0, FULL = 2'd1, BUBBLE = 2'd2.
  - `FETCH_DEPTH` = 2.
  - `NOP_INST` = 32'h0000_0013 (firmware returns it for BUBBLE_ADDR).
- Sub-module `fetch_skid_buf`: 2-entry 64-bit (inst+pc) buffer with push, pop, flush and occupancy; all handshake and address logic stays in the top module.

Test Plan:
- Reset, RESET_PC = 0, `dec_ready` = 1, pulses 0x00A00093 @0 and 0x00100113 @4 → `dec_pc` 0 then 4 one cycle after each pulse; `inst_mem_addr` steps 0→4→8.
- `dec_ready` = 0, two pulses at 0 and 4 → occupancy 2, state FULL, `inst_mem_addr` held at 4. Then `dec_ready` = 1 for one cycle → address goes to 8; next instruction out is @0.
- Occupancy 1, `redirect_valid` with `redirect_pc` = 0x40 in the same cycle as a pulse → `dec_valid` = 0 next cycle, pulse dropped, `inst_mem_addr` = 0x40.
- FULL at address 8, redirect to 8 → one cycle at 0xFFFFFFFC, then 8; the pulse for 0xFFFFFFFC is discarded; the next pulse delivers @8.
- Assert `reset` while in FULL with occupancy 2 → next cycle `dec_valid` = 0, `inst_mem_addr` = RESET_PC, state FETCH.
- FETCH_PERF_CNT_EN: 3 pulses, each after 5 stall cycles → `perf_fetched` = 3, `perf_stall_cycles` = 15.
